dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 54 +++++
 rtl/dmem_arbiter.sv | 89 ++++++++
 tb/tb_dmem_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Purpose: bundles the CPU port, the loader/debug port, the data memory side and Busy.
// Latency: no logic here; the arbiter timing is documented in dmem_arbiter.
// Backpressure: req is held until gnt. The memory side has no stall, so there is no backpressure.
// Ports: C_* is the CPU requester and L_* is the loader/debug requester.
//        M_* is the synchronous-read data memory. Busy is the arbiter status.
// Modports: slave is the arbiter side; master is the requesters plus memory (environment) side.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  // CPU port
  logic          C_req;
  logic          C_wr;
  logic [AW-1:0] C_addr;
  logic [DW-1:0] C_wdata;
  logic          C_gnt;
  logic          C_rvalid;
  logic [DW-1:0] C_rdata;
  // Loader/debug port
  logic          L_req;
  logic          L_wr;
  logic [AW-1:0] L_addr;
  logic [DW-1:0] L_wdata;
  logic          L_gnt;
  logic          L_rvalid;
  logic [DW-1:0] L_rdata;
  // Memory side
  logic [AW-1:0] M_addr;
  logic          M_wr;
  logic [DW-1:0] M_wdata;
  logic [DW-1:0] M_rdata;
  // Status
  logic          Busy;

  modport slave (
    input  C_req, C_wr, C_addr, C_wdata,
    output C_gnt, C_rvalid, C_rdata,
    input  L_req, L_wr, L_addr, L_wdata,
    output L_gnt, L_rvalid, L_rdata,
    output M_addr, M_wr, M_wdata,
    input  M_rdata,
    output Busy
  );

  modport master (
    output C_req, C_wr, C_addr, C_wdata,
    input  C_gnt, C_rvalid, C_rdata,
    output L_req, L_wr, L_addr, L_wdata,
    input  L_gnt, L_rvalid, L_rdata,
    input  M_addr, M_wr, M_wdata,
    output M_rdata,
    input  Busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose: two-port (CPU and loader) round-robin arbiter in front of a synchronous-read data memory.
// Latency: a request sampled in IDLE at cycle T gives gnt and the memory write at T+1, and read rvalid at T+3.
// Backpressure: the arbiter samples requests only in IDLE. A requester holds req until it sees gnt.
// Ports: Clock and Reset (synchronous, active-high) are plain ports.
//        bus (dmem_arbiter_if.slave) carries the C_*, L_* and M_* signals and Busy.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic           Clock,
  input  logic           Reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

  state_t        state_q, state_d;
  logic          ptr_q;      // last served: 1 = L, 0 = C
  logic          id_q;       // current winner: 1 = L, 0 = C
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          c_rvalid_q, l_rvalid_q;
  logic [DW-1:0] c_rdata_q, l_rdata_q;
  logic          win_l;
  logic          load;

  // L wins when it is the only requester, or on a tie when C was served last.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    win_l   = bus.L_req & (~bus.C_req | ~ptr_q);
    case (state_q)
      IDLE: begin
        if (bus.C_req | bus.L_req) begin
          load    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = wr_q ? IDLE : RDATA;
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b1;
      id_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      c_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      l_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        id_q    <= win_l;
        ptr_q   <= win_l;
        wr_q    <= win_l ? bus.L_wr    : bus.C_wr;
        addr_q  <= win_l ? bus.L_addr  : bus.C_addr;
        wdata_q <= win_l ? bus.L_wdata : bus.C_wdata;
      end
      // Memory data is valid during RDATA; capture it into the winner's register only.
      c_rvalid_q <= (state_q == RDATA) & ~id_q;
      l_rvalid_q <= (state_q == RDATA) &  id_q;
      if (state_q == RDATA) begin
        if (id_q) l_rdata_q <= bus.M_rdata;
        else      c_rdata_q <= bus.M_rdata;
      end
    end
  end

  // The address and data registers double as the memory-side outputs. They hold outside ACCESS.
  assign bus.M_addr   = addr_q;
  assign bus.M_wdata  = wdata_q;
  assign bus.M_wr     = (state_q == ACCESS) & wr_q;
  assign bus.C_gnt    = (state_q == ACCESS) & ~id_q;
  assign bus.L_gnt    = (state_q == ACCESS) &  id_q;
  assign bus.C_rvalid = c_rvalid_q;
  assign bus.L_rvalid = l_rvalid_q;
  assign bus.C_rdata  = c_rdata_q;
  assign bus.L_rdata  = l_rdata_q;
  assign bus.Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: directed, table-driven checks of dmem_arbiter against hand-computed cycle-by-cycle outputs.
// Latency: each vector drives its inputs, steps one clock, then compares the outputs 1 time unit later.
// Backpressure: requesters deassert req in the vector after they see their gnt.
module tb_dmem_arbiter;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  dmem_arbiter_if #(.AW(8), .DW(16)) bus ();

  dmem_arbiter #(.AW(8), .DW(16)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  // Environment: synchronous-read data memory
  logic [15:0] mem [0:255];
  logic [15:0] mem_rdata = 16'h0;
  always @(posedge Clock) begin
    if (bus.M_wr) mem[bus.M_addr] <= bus.M_wdata;
    mem_rdata <= mem[bus.M_addr];
  end
  assign bus.M_rdata = mem_rdata;

  // flags = {C_gnt, L_gnt, C_rvalid, L_rvalid, M_wr, Busy}
  typedef struct {
    logic        rst;
    logic        creq;
    logic        cwr;
    logic [7:0]  caddr;
    logic [15:0] cwd;
    logic        lreq;
    logic        lwr;
    logic [7:0]  laddr;
    logic [15:0] lwd;
    logic [5:0]  flags;
    logic [7:0]  maddr;
    logic [15:0] mwd;
    logic [15:0] crd;
    logic [15:0] lrd;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic rst, input logic creq, input logic cwr, input logic [7:0] caddr,
                     input logic [15:0] cwd, input logic lreq, input logic lwr, input logic [7:0] laddr,
                     input logic [15:0] lwd, input logic [5:0] flags, input logic [7:0] maddr,
                     input logic [15:0] mwd, input logic [15:0] crd, input logic [15:0] lrd);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwr = cwr; v.caddr = caddr; v.cwd = cwd;
    v.lreq = lreq; v.lwr = lwr; v.laddr = laddr; v.lwd = lwd;
    v.flags = flags; v.maddr = maddr; v.mwd = mwd; v.crd = crd; v.lrd = lrd;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic rst, input logic creq, input logic cwr, input logic [7:0] caddr,
                       input logic lreq, input logic lwr, input logic [7:0] laddr);
    Reset = rst;
    bus.C_req = creq; bus.C_wr = cwr; bus.C_addr = caddr; bus.C_wdata = 16'h0;
    bus.L_req = lreq; bus.L_wr = lwr; bus.L_addr = laddr; bus.L_wdata = 16'h0;
  endtask

  initial begin
    logic [61:0] act_v, exp_v;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h34] = 16'h1234;
    mem[8'h10] = 16'hAAAA;
    mem[8'h11] = 16'h5555;
    drive(1'b1, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 8'h0);

    //  rst creq cwr caddr  cwd       lreq lwr laddr  lwd       flags      maddr  mwd       crd       lrd
    // Reset, then a single CPU write
    add(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b000000, 8'h00, 16'h0000, 16'h0000, 16'h0000);
    add(0, 1, 1, 8'h12, 16'hBEEF, 0, 0, 8'h00, 16'h0000, 6'b100011, 8'h12, 16'hBEEF, 16'h0000, 16'h0000);
    add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b000000, 8'h12, 16'hBEEF, 16'h0000, 16'h0000);
    add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b000000, 8'h12, 16'hBEEF, 16'h0000, 16'h0000);
    // L read of 0x34
    add(0, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h34, 16'h0000, 6'b010001, 8'h34, 16'h0000, 16'h0000, 16'h0000);
    add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b000001, 8'h34, 16'h0000, 16'h0000, 16'h0000);
    add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b000100, 8'h34, 16'h0000, 16'h0000, 16'h1234);
    add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b000000, 8'h34, 16'h0000, 16'h0000, 16'h1234);
    // Reset, then a simultaneous write tie: C wins first, then L
    add(1, 1, 1, 8'h01, 16'h1111, 1, 1, 8'h02, 16'h2222, 6'b000000, 8'h00, 16'h0000, 16'h0000, 16'h0000);
    add(0, 1, 1, 8'h01, 16'h1111, 1, 1, 8'h02, 16'h2222, 6'b100011, 8'h01, 16'h1111, 16'h0000, 16'h0000);
    add(0, 0, 0, 8'h00, 16'h0000, 1, 1, 8'h02, 16'h2222, 6'b000000, 8'h01, 16'h1111, 16'h0000, 16'h0000);
    add(0, 0, 0, 8'h00, 16'h0000, 1, 1, 8'h02, 16'h2222, 6'b010011, 8'h02, 16'h2222, 16'h0000, 16'h0000);
    add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b000000, 8'h02, 16'h2222, 16'h0000, 16'h0000);
    // Back-to-back C reads; the second request is sampled in the first rvalid cycle
    add(0, 1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b100001, 8'h10, 16'h0000, 16'h0000, 16'h0000);
    add(0, 1, 0, 8'h11, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b000001, 8'h10, 16'h0000, 16'h0000, 16'h0000);
    add(0, 1, 0, 8'h11, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b001000, 8'h10, 16'h0000, 16'hAAAA, 16'h0000);
    add(0, 1, 0, 8'h11, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b100001, 8'h11, 16'h0000, 16'hAAAA, 16'h0000);
    add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b000001, 8'h11, 16'h0000, 16'hAAAA, 16'h0000);
    add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b001000, 8'h11, 16'h0000, 16'h5555, 16'h0000);
    // C read of 0x34; L arrives during RDATA and is granted after C_rvalid
    add(0, 1, 0, 8'h34, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b100001, 8'h34, 16'h0000, 16'h5555, 16'h0000);
    add(0, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h10, 16'h0000, 6'b000001, 8'h34, 16'h0000, 16'h5555, 16'h0000);
    add(0, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h10, 16'h0000, 6'b001000, 8'h34, 16'h0000, 16'h1234, 16'h0000);
    add(0, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h10, 16'h0000, 6'b010001, 8'h10, 16'h0000, 16'h1234, 16'h0000);
    add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b000001, 8'h10, 16'h0000, 16'h1234, 16'h0000);
    add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b000100, 8'h10, 16'h0000, 16'h1234, 16'hAAAA);
    // Reset during ACCESS of an L read aborts it
    add(0, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h11, 16'h0000, 6'b010001, 8'h11, 16'h0000, 16'h1234, 16'hAAAA);
    add(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b000000, 8'h00, 16'h0000, 16'h0000, 16'h0000);
    add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b000000, 8'h00, 16'h0000, 16'h0000, 16'h0000);
    add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 6'b000000, 8'h00, 16'h0000, 16'h0000, 16'h0000);

    foreach (vq[i]) begin
      Reset       = vq[i].rst;
      bus.C_req   = vq[i].creq;  bus.C_wr = vq[i].cwr;  bus.C_addr = vq[i].caddr;  bus.C_wdata = vq[i].cwd;
      bus.L_req   = vq[i].lreq;  bus.L_wr = vq[i].lwr;  bus.L_addr = vq[i].laddr;  bus.L_wdata = vq[i].lwd;
      step();
      act_v = {bus.C_gnt, bus.L_gnt, bus.C_rvalid, bus.L_rvalid, bus.M_wr, bus.Busy,
               bus.M_addr, bus.M_wdata, bus.C_rdata, bus.L_rdata};
      exp_v = {vq[i].flags, vq[i].maddr, vq[i].mwd, vq[i].crd, vq[i].lrd};
      chk($sformatf("vec%0d", i), {2'b00, act_v}, {2'b00, exp_v});
    end

    // Reset during RDATA of a C read: no rvalid and no rdata update
    drive(1'b0, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 8'h00);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step();
    chk("rdata_state_busy", {63'h0, bus.Busy}, 64'h1);
    Reset = 1'b1;
    step();
    chk("rst_rdata_busy", {63'h0, bus.Busy}, 64'h0);
    chk("rst_rdata_rdata", {48'h0, bus.C_rdata}, 64'h0);
    Reset = 1'b0;
    step();
    chk("rst_rdata_rvalid", {62'h0, bus.C_rvalid, bus.M_wr}, 64'h0);
    chk("rst_rdata_rdata2", {48'h0, bus.C_rdata}, 64'h0);

    // Read tie after reset: C wins, then L is granted and completes within a bounded wait
    drive(1'b0, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 8'h34);
    step();
    chk("tie_gnt", {62'h0, bus.C_gnt, bus.L_gnt}, 64'h2);
    bus.C_req = 1'b0;
    n = 0;
    while (!bus.L_gnt && n < 10) begin
      step();
      n++;
    end
    chk("l_gnt_wait", 64'(n), 64'd3);
    bus.L_req = 1'b0;
    n = 0;
    while (!bus.L_rvalid && n < 10) begin
      step();
      n++;
    end
    chk("l_rvalid_wait", 64'(n), 64'd2);
    chk("l_rdata", {48'h0, bus.L_rdata}, 64'h1234);
    chk("c_rdata_kept", {48'h0, bus.C_rdata}, 64'hAAAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
